user_io_event_capture: RTL and testbench

- Sits directly downstream of the south-terminal user-project IO tile, on the user-project side.
- Consumes the 20 fabric-to-user lines that the IO tile passes through.
- Each time the sampled word changes, it records the new value and a free-running timestamp in a small FIFO.
- User logic drains the FIFO over a valid/ready handshake. Overflow is counted and flagged, never silently lost.

---
 rtl/user_io_pkg.sv | 14 +
 rtl/user_io_evt_fifo.sv | 63 ++++++
 rtl/user_io_event_capture.sv | 123 ++++++++++++
 tb/tb_user_io_event_capture.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/user_io_pkg.sv
// Shared constants and the FIFO storage word for the user-side IO event capture block.
package user_io_pkg;

    localparam int USER_IO_WIDTH      = 20;
    localparam int USER_IO_DEPTH      = 8;
    localparam int USER_IO_TS_WIDTH   = 12;
    localparam int USER_IO_DROP_WIDTH = 8;

    typedef struct packed {
        logic [USER_IO_WIDTH-1:0]    data;
        logic [USER_IO_TS_WIDTH-1:0] ts;
    } user_io_evt_t;

endpackage

// File: rtl/user_io_evt_fifo.sv
// Synchronous FIFO, no fall-through: a push is visible at the head one cycle later.
// Push when full is refused unless a pop happens on the same edge; pop when empty is ignored.
module user_io_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;
    assign dout  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/user_io_event_capture.sv
// Records each change of the fabric word with a timestamp into a FIFO; USER_IO_CAPTURE_SYNC_EN adds a 2-flop input synchronizer.
// Push two edges after fab_in changes (four with the synchronizer); full FIFO without a pop drops and counts the event.
module user_io_event_capture
    import user_io_pkg::*;
#(
    parameter int WIDTH      = USER_IO_WIDTH,
    parameter int DEPTH      = USER_IO_DEPTH,
    parameter int TS_WIDTH   = USER_IO_TS_WIDTH,
    parameter int DROP_WIDTH = USER_IO_DROP_WIDTH,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                  UserCLK,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      fab_in,
    input  logic                  enable,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [WIDTH-1:0]      evt_data,
    output logic [TS_WIDTH-1:0]   evt_ts,
    output logic                  overflow,
    input  logic                  clr_ovf,
    output logic [DROP_WIDTH-1:0] drop_cnt,
    output logic [LW-1:0]         fifo_level
);

    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [WIDTH-1:0]      samp_q, samp_d;
    logic [WIDTH-1:0]      prev_q, prev_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
`ifdef USER_IO_CAPTURE_SYNC_EN
    logic [WIDTH-1:0]      sync1_q, sync1_d;
    logic [WIDTH-1:0]      sync2_q, sync2_d;
`endif

    logic         chg;
    logic         pop;
    logic         drop;
    logic         fifo_full;
    logic         fifo_empty;
    user_io_evt_t push_evt;
    user_io_evt_t head_evt;

    always_comb begin
        chg  = enable && (samp_q != prev_q);
        pop  = !fifo_empty && evt_ready;
        drop = chg && fifo_full && !pop;

        push_evt.data = samp_q;
        push_evt.ts   = ts_q;

        ts_d   = ts_q + 1'b1;
        prev_d = samp_q;
`ifdef USER_IO_CAPTURE_SYNC_EN
        sync1_d = fab_in;
        sync2_d = sync1_q;
        samp_d  = sync2_q;
`else
        samp_d  = fab_in;
`endif

        // A drop in the same cycle as a clear leaves a fresh count of one.
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf) begin
                drop_cnt_d = DROP_WIDTH'(1);
            end else if (drop_cnt_q != '1) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge UserCLK) begin
        if (rst) begin
            ts_q       <= '0;
            samp_q     <= '0;
            prev_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
`ifdef USER_IO_CAPTURE_SYNC_EN
            sync1_q    <= '0;
            sync2_q    <= '0;
`endif
        end else begin
            ts_q       <= ts_d;
            samp_q     <= samp_d;
            prev_q     <= prev_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef USER_IO_CAPTURE_SYNC_EN
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
`endif
        end
    end

    user_io_evt_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(user_io_evt_t))
    ) u_fifo (
        .clk   (UserCLK),
        .rst   (rst),
        .push  (chg),
        .pop   (pop),
        .din   (push_evt),
        .dout  (head_evt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign evt_valid = !fifo_empty;
    assign evt_data  = head_evt.data;
    assign evt_ts    = head_evt.ts;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_user_io_event_capture.sv
// Directed bench for user_io_event_capture: a queue model checked every cycle plus literal expectations.
module tb_user_io_event_capture;
    import user_io_pkg::*;

`ifdef USER_IO_CAPTURE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif
    localparam int DEPTH = 8;

    logic        UserCLK = 1'b0;
    logic        rst;
    logic [19:0] fab_in;
    logic        enable;
    logic        evt_valid;
    logic        evt_ready;
    logic [19:0] evt_data;
    logic [11:0] evt_ts;
    logic        overflow;
    logic        clr_ovf;
    logic [7:0]  drop_cnt;
    logic [3:0]  fifo_level;

    int n_vec = 0;
    int n_err = 0;

    // Model state: input history (index 0 = most recently sampled edge), event queue, flags.
    logic [19:0]  hist [4];
    user_io_evt_t mq[$];
    logic [11:0]  m_ts;
    logic         m_ovf;
    logic [7:0]   m_drop;
    bit           m_rst  = 1'b0;
    bit           m_live = 1'b0;

    always #5 UserCLK = ~UserCLK;

    user_io_event_capture dut (
        .UserCLK    (UserCLK),
        .rst        (rst),
        .fab_in     (fab_in),
        .enable     (enable),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_ts     (evt_ts),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Event at an edge when enabled and the word seen LAT+1 edges ago differs from the one before it.
    task automatic model_edge();
        bit chg_m;
        bit pop_m;
        if (rst) begin
            mq.delete();
            for (int i = 0; i < 4; i++) hist[i] = '0;
            m_ts   = '0;
            m_ovf  = 1'b0;
            m_drop = '0;
            m_rst  = 1'b1;
            m_live = 1'b1;
            return;
        end
        m_rst = 1'b0;
        chg_m = enable && (hist[LAT] != hist[LAT+1]);
        pop_m = (mq.size() > 0) && evt_ready;
        if (pop_m) void'(mq.pop_front());
        if (chg_m && mq.size() < DEPTH) begin
            mq.push_back(user_io_evt_t'{data: hist[LAT], ts: m_ts});
            if (clr_ovf) begin m_ovf = 1'b0; m_drop = '0; end
        end else if (chg_m) begin
            m_ovf  = 1'b1;
            m_drop = clr_ovf ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
        end else if (clr_ovf) begin
            m_ovf  = 1'b0;
            m_drop = '0;
        end
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = fab_in;
        m_ts    = m_ts + 12'd1;
    endtask

    task automatic compare();
        if (!m_live) return;
        check("evt_valid", {31'd0, evt_valid}, {31'd0, mq.size() > 0});
        check("fifo_level", {28'd0, fifo_level}, mq.size());
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("drop_cnt", {24'd0, drop_cnt}, {24'd0, m_drop});
        if (mq.size() > 0) begin
            check("evt_data", {12'd0, evt_data}, {12'd0, mq[0].data});
            check("evt_ts", {20'd0, evt_ts}, {20'd0, mq[0].ts});
        end
        if (m_rst) begin
            check("rst_evt_data", {12'd0, evt_data}, 32'd0);
            check("rst_evt_ts", {20'd0, evt_ts}, 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        model_edge();
        @(negedge UserCLK);
        compare();
    endtask

    logic [19:0] tv [5];

    initial begin
        tv[0] = 20'h12345; tv[1] = 20'h54321; tv[2] = 20'h0F0F0;
        tv[3] = 20'hABCDE; tv[4] = 20'h00001;
        rst = 1'b1; fab_in = '0; enable = 1'b1; evt_ready = 1'b0; clr_ovf = 1'b0;

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        check("idle_level", {28'd0, fifo_level}, 32'd0);
        check("idle_valid", {31'd0, evt_valid}, 32'd0);
        check("idle_ovf", {31'd0, overflow}, 32'd0);

        // Single change: 20 edges since reset, so the event carries ts 21 (+LAT)
        evt_ready = 1'b1;
        fab_in    = 20'h00A5F;
        tick();
        repeat (LAT + 1) tick();
        check("single_valid", {31'd0, evt_valid}, 32'd1);
        check("single_data", {12'd0, evt_data}, 32'h00A5F);
        check("single_ts", {20'd0, evt_ts}, 32'd21 + LAT);
        tick();
        check("single_pulse_end", {31'd0, evt_valid}, 32'd0);

        // Enable gating
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fab_in = tv[i];
            tick();
        end
        repeat (4) tick();
        enable = 1'b1;
        repeat (6) tick();
        check("gate_level", {28'd0, fifo_level}, 32'd0);
        evt_ready = 1'b0;
        fab_in    = 20'hFFFFF;
        repeat (LAT + 2) tick();
        check("gate_one_level", {28'd0, fifo_level}, 32'd1);
        check("gate_one_data", {12'd0, evt_data}, 32'hFFFFF);
        repeat (3) tick();
        check("gate_exactly_one", {28'd0, fifo_level}, 32'd1);
        evt_ready = 1'b1;
        tick();
        check("gate_drained", {28'd0, fifo_level}, 32'd0);

        // Overflow: 10 changes into an 8-deep FIFO
        evt_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            fab_in = 20'(i);
            tick();
        end
        repeat (LAT + 2) tick();
        check("ovf_level", {28'd0, fifo_level}, 32'd8);
        check("ovf_drop", {24'd0, drop_cnt}, 32'd2);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        evt_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check("drain_order", {12'd0, evt_data}, i);
            tick();
        end
        evt_ready = 1'b0;
        check("drain_empty", {28'd0, fifo_level}, 32'd0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf_flag", {31'd0, overflow}, 32'd0);
        check("clr_drop_cnt", {24'd0, drop_cnt}, 32'd0);

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 8; i++) begin
            fab_in = 20'h00100 + 20'(i);
            tick();
        end
        repeat (LAT + 2) tick();
        check("full_level", {28'd0, fifo_level}, 32'd8);
        fab_in = 20'h00200;
        repeat (LAT + 1) tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("pushpop_level", {28'd0, fifo_level}, 32'd8);
        check("pushpop_drop", {24'd0, drop_cnt}, 32'd0);
        check("pushpop_ovf", {31'd0, overflow}, 32'd0);

        // Backpressure: head holds
        repeat (5) tick();
        check("hold_data", {12'd0, evt_data}, 32'h00101);

        // Reset with 4 entries queued
        evt_ready = 1'b1;
        repeat (4) tick();
        evt_ready = 1'b0;
        check("pre_rst_level", {28'd0, fifo_level}, 32'd4);
        check("pre_rst_head", {12'd0, evt_data}, 32'h00105);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_level", {28'd0, fifo_level}, 32'd0);
        fab_in = 20'h00005;
        repeat (LAT + 2) tick();
        check("post_rst_data", {12'd0, evt_data}, 32'h00005);
        check("post_rst_ts", {20'd0, evt_ts}, 32'd1 + LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
